// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes,
// FSM state encoding and the default bus timeout.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REQ      = 2'b01,
    WAIT_RSP = 2'b10,
    DONE     = 2'b11
  } lsu_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory system (slave).
interface mem_stage_lsu_if;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic [3:0]  dmem_req_wstrb;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;

  modport master (
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_rsp_valid, dmem_rsp_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store shift/strobes, load selection/extension
// and the misaligned/unsupported access check.
module lsu_align
  import mem_pkg::*;
(
  input  logic        access,
  input  logic        is_read,
  input  logic        is_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic        bad_op_s;
  logic        misal_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Fault check; read+write together and unsigned stores count as unsupported
  always_comb begin
    bad_op_s = is_read & is_write;
    misal_s  = 1'b0;
    case (funct3)
      F3_B:    misal_s = 1'b0;
      F3_BU:   bad_op_s = bad_op_s | is_write;
      F3_H:    misal_s = offset[0];
      F3_HU:   begin misal_s = offset[0]; bad_op_s = bad_op_s | is_write; end
      F3_W:    misal_s = (offset != 2'b00);
      default: bad_op_s = 1'b1;
    endcase
    fault = access & (bad_op_s | misal_s);
  end

  // Store data replication and byte strobes
  always_comb begin
    wdata = 32'h0000_0000;
    wstrb = 4'b0000;
    if (is_write) begin
      case (funct3)
        F3_B:    begin wdata = {4{store_data[7:0]}};  wstrb = 4'b0001 << offset; end
        F3_H:    begin wdata = {2{store_data[15:0]}}; wstrb = 4'b0011 << offset; end
        F3_W:    begin wdata = store_data;            wstrb = 4'b1111; end
        default: begin wdata = 32'h0000_0000;         wstrb = 4'b0000; end
      endcase
    end else begin
      wdata = 32'h0000_0000;
      wstrb = 4'b0000;
    end
  end

  // Load lane selection and sign/zero extension
  always_comb begin
    case (ld_offset)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      default: byte_s = rdata[31:24];
    endcase
    half_s = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_BU:   load_data = {24'h00_0000, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_HU:   load_data = {16'h0000, half_s};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns memory instructions into bus transactions,
// stalls the pipeline until the response and delivers aligned load data.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_WIDTH      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic            mem_memRead,
  input  logic            mem_memWrite,
  input  logic [2:0]      mem_funct3,
  input  logic [31:0]     mem_ALUResult,
  input  logic [31:0]     mem_storeData,
  mem_stage_lsu_if.master dmem,
  output logic [31:0]     mem_dataFromRAM,
  output logic            mem_stall,
  output logic            mem_misaligned,
  output logic            mem_busErr
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  lsu_state_t           state_r, next_s;
  logic [CNT_WIDTH-1:0] cnt_r;
  logic                 req_valid_r, req_we_r;
  logic [31:0]          req_addr_r, req_wdata_r, data_r;
  logic [3:0]           req_wstrb_r;
  logic [2:0]           ld_funct3_r;
  logic [1:0]           ld_offset_r;
  logic                 bus_err_r;

  logic        access_s, fault_s, start_s, timeout_s, take_rsp_s, cnt_last_s;
  logic [31:0] wdata_s, load_data_s;
  logic [3:0]  wstrb_s;

  assign access_s   = mem_valid & (mem_memRead | mem_memWrite);
  assign cnt_last_s = (cnt_r == CNT_LAST);

  lsu_align u_align (
    .access     (access_s),
    .is_read    (mem_memRead),
    .is_write   (mem_memWrite),
    .funct3     (mem_funct3),
    .offset     (mem_ALUResult[1:0]),
    .store_data (mem_storeData),
    .ld_funct3  (ld_funct3_r),
    .ld_offset  (ld_offset_r),
    .rdata      (dmem.dmem_rsp_rdata),
    .fault      (fault_s),
    .wdata      (wdata_s),
    .wstrb      (wstrb_s),
    .load_data  (load_data_s)
  );

  // Next-state logic; a timeout in REQ beats a same-cycle handshake, a response beats it in WAIT_RSP
  always_comb begin
    next_s     = state_r;
    start_s    = 1'b0;
    timeout_s  = 1'b0;
    take_rsp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s && !fault_s) begin next_s = REQ; start_s = 1'b1; end
        else next_s = IDLE;
      end
      REQ: begin
        if (cnt_last_s) begin next_s = DONE; timeout_s = 1'b1; end
        else if (dmem.dmem_req_ready) next_s = WAIT_RSP;
        else next_s = REQ;
      end
      WAIT_RSP: begin
        if (dmem.dmem_rsp_valid) begin next_s = DONE; take_rsp_s = 1'b1; end
        else if (cnt_last_s) begin next_s = DONE; timeout_s = 1'b1; end
        else next_s = WAIT_RSP;
      end
      DONE:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register and timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= next_s;
      if (start_s) cnt_r <= {CNT_WIDTH{1'b0}};
      else if (state_r == REQ || state_r == WAIT_RSP) cnt_r <= cnt_r + CNT_WIDTH'(1);
      else cnt_r <= cnt_r;
    end
  end

  // Request registers, latched once at access start and held while waiting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_valid_r <= 1'b0;
      req_we_r    <= 1'b0;
      req_addr_r  <= 32'h0000_0000;
      req_wdata_r <= 32'h0000_0000;
      req_wstrb_r <= 4'b0000;
      ld_funct3_r <= 3'b000;
      ld_offset_r <= 2'b00;
    end else begin
      req_valid_r <= (next_s == REQ);
      if (start_s) begin
        req_we_r    <= mem_memWrite;
        req_addr_r  <= word_align(mem_ALUResult);
        req_wdata_r <= wdata_s;
        req_wstrb_r <= wstrb_s;
        ld_funct3_r <= mem_funct3;
        ld_offset_r <= mem_ALUResult[1:0];
      end
    end
  end

  // Load result and bus error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r    <= 32'h0000_0000;
      bus_err_r <= 1'b0;
    end else begin
      if (timeout_s) data_r <= 32'h0000_0000;
      else if (take_rsp_s && !req_we_r) data_r <= load_data_s;
      else data_r <= data_r;
      if (timeout_s) bus_err_r <= 1'b1;
      else if (state_r == DONE) bus_err_r <= 1'b0;
      else bus_err_r <= bus_err_r;
    end
  end

  assign dmem.dmem_req_valid = req_valid_r;
  assign dmem.dmem_req_we    = req_we_r;
  assign dmem.dmem_req_addr  = req_addr_r;
  assign dmem.dmem_req_wdata = req_wdata_r;
  assign dmem.dmem_req_wstrb = req_wstrb_r;
  assign mem_dataFromRAM     = data_r;
  assign mem_busErr          = bus_err_r;
  assign mem_stall      = rst_n & ((state_r == IDLE && access_s && !fault_s) ||
                                   state_r == REQ || state_r == WAIT_RSP);
  assign mem_misaligned = rst_n & fault_s;

endmodule
